tm_inference_scheduler: RTL

Sequences one shared combinational clause evaluator across all clauses of a multi-class Tsetlin machine for Iris inference.
- Holds per-clause exclude masks in an internal register file, loaded over a config port.
- Latches one feature vector per inference and evaluates one clause per cycle.
- Accumulates polarity-weighted votes per class and outputs the argmax class with its sum.

---
 rtl/tm_pkg.sv | 22 ++
 rtl/tm_clause_eval.sv | 23 ++
 rtl/tm_inference_scheduler.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/tm_pkg.sv
// Shared constants and state type for the Tsetlin machine inference scheduler.
// Optional build macro used elsewhere in this slice: TM_EMPTY_CLAUSE_MASK_EN.
package tm_pkg;

  localparam int NUM_FEATURES      = 9;
  localparam int NUM_LITERALS      = 2 * NUM_FEATURES;
  localparam int NUM_CLASSES       = 3;
  localparam int CLAUSES_PER_CLASS = 12;
  localparam int NUM_CLAUSES       = NUM_CLASSES * CLAUSES_PER_CLASS;
  localparam int SUM_W             = 5;

  localparam int ADDR_W  = $clog2(NUM_CLAUSES);
  localparam int CLASS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int JDX_W   = $clog2(CLAUSES_PER_CLASS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } tm_state_e;

endpackage

// File: rtl/tm_clause_eval.sv
// Combinational clause evaluator: literals {f, ~f}, excluded literals forced to 1, AND-reduce.
// With TM_EMPTY_CLAUSE_MASK_EN defined, a clause that excludes every literal outputs 0.
module tm_clause_eval
  import tm_pkg::*;
(
  input  logic [NUM_FEATURES-1:0] i_features,
  input  logic [NUM_LITERALS-1:0] i_mask,
  output logic                    o_clause
);

  logic [NUM_LITERALS-1:0] w_literals;
  logic [NUM_LITERALS-1:0] w_forced;

  assign w_literals = {i_features, ~i_features};
  assign w_forced   = w_literals | i_mask;

`ifdef TM_EMPTY_CLAUSE_MASK_EN
  assign o_clause = (&w_forced) & ~(&i_mask);
`else
  assign o_clause = &w_forced;
`endif

endmodule

// File: rtl/tm_inference_scheduler.sv
// Time-multiplexes one clause evaluator over all clauses and reports the argmax class.
// Clause semantics for all-excluded masks depend on TM_EMPTY_CLAUSE_MASK_EN.
module tm_inference_scheduler
  import tm_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [ADDR_W-1:0]       cfg_addr,
  input  logic [NUM_LITERALS-1:0] cfg_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_FEATURES-1:0] in_features,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CLASS_W-1:0]      out_class,
  output logic signed [SUM_W-1:0] out_sum
);

  tm_state_e r_state;
  tm_state_e w_next_state;

  logic [NUM_LITERALS-1:0] r_mask [NUM_CLAUSES];
  logic [NUM_FEATURES-1:0] r_features;
  logic [ADDR_W-1:0]       r_cnt;
  logic [CLASS_W-1:0]      r_cls;
  logic [JDX_W-1:0]        r_jdx;
  logic signed [SUM_W-1:0] r_sum [NUM_CLASSES];

  logic                    r_in_ready;
  logic                    r_out_valid;
  logic [CLASS_W-1:0]      r_out_class;
  logic signed [SUM_W-1:0] r_out_sum;

  logic                    w_accept;
  logic                    w_cfg_wr;
  logic                    w_last;
  logic                    w_release;
  logic                    w_clause_out;
  logic signed [SUM_W-1:0] w_vote;
  logic [CLASS_W-1:0]      w_best_class;
  logic signed [SUM_W-1:0] w_best_sum;

  assign w_accept  = (r_state == IDLE) && in_valid && r_in_ready;
  assign w_cfg_wr  = (r_state == IDLE) && cfg_we && (cfg_addr < ADDR_W'(NUM_CLAUSES));
  assign w_last    = (r_cnt == ADDR_W'(NUM_CLAUSES - 1));
  assign w_release = r_out_valid && out_ready;
  // Even clauses vote for their class, odd clauses against it.
  assign w_vote    = r_jdx[0] ? {SUM_W{1'b1}} : SUM_W'(1);

  tm_clause_eval u_clause_eval (
    .i_features (r_features),
    .i_mask     (r_mask[r_cnt]),
    .o_clause   (w_clause_out)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = EVAL;
        end else begin
          w_next_state = IDLE;
        end
      end
      EVAL: begin
        if (w_last) begin
          w_next_state = DONE;
        end else begin
          w_next_state = EVAL;
        end
      end
      DONE: begin
        if (w_release) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = DONE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state == IDLE);
    end
  end

  // Masks only change while idle, so an inference always sees a stable clause set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLAUSES; i++) begin
        r_mask[i] <= '1;
      end
    end else if (w_cfg_wr) begin
      r_mask[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_features <= '0;
      r_cnt      <= '0;
      r_cls      <= '0;
      r_jdx      <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        r_sum[c] <= '0;
      end
    end else if (w_accept) begin
      r_features <= in_features;
      r_cnt      <= '0;
      r_cls      <= '0;
      r_jdx      <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        r_sum[c] <= '0;
      end
    end else if (r_state == EVAL) begin
      if (w_clause_out) begin
        r_sum[r_cls] <= r_sum[r_cls] + w_vote;
      end
      if (w_last) begin
        r_cnt <= '0;
        r_cls <= '0;
        r_jdx <= '0;
      end else begin
        r_cnt <= r_cnt + ADDR_W'(1);
        if (r_jdx == JDX_W'(CLAUSES_PER_CLASS - 1)) begin
          r_jdx <= '0;
          r_cls <= r_cls + CLASS_W'(1);
        end else begin
          r_jdx <= r_jdx + JDX_W'(1);
        end
      end
    end
  end

  // Strict greater-than keeps the lowest class index on ties.
  always_comb begin
    w_best_class = '0;
    w_best_sum   = r_sum[0];
    for (int c = 1; c < NUM_CLASSES; c++) begin
      if (r_sum[c] > w_best_sum) begin
        w_best_class = CLASS_W'(c);
        w_best_sum   = r_sum[c];
      end else begin
        w_best_class = w_best_class;
        w_best_sum   = w_best_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_class <= '0;
      r_out_sum   <= '0;
    end else if ((r_state == DONE) && !r_out_valid) begin
      r_out_valid <= 1'b1;
      r_out_class <= w_best_class;
      r_out_sum   <= w_best_sum;
    end else if (w_release) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_class = r_out_class;
  assign out_sum   = r_out_sum;

endmodule
